mem_access_unit: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Issues loads and stores to data memory over a valid/ready request bus, with byte, halfword and word handling.
- Stalls the upstream pipeline while memory is busy.
- Drives registered MEM/WB outputs, including sign/zero-extended load data, misalignment flagging and bus-timeout recovery.

---
 rtl/mem_access_unit_pkg.sv | 12 +
 rtl/load_store_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: shared encodings for the MEM-stage access unit
package mem_access_unit_pkg;
    localparam logic [1:0] RS_ALU  = 2'b00;
    localparam logic [1:0] RS_LOAD = 2'b01;
    localparam logic [1:0] RS_PC4  = 2'b10;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic {S_IDLE, S_WAIT} state_t;
endpackage

// File: rtl/load_store_align.sv
// load_store_align: byte enables, store lane replication, misalignment and load extension
module load_store_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic        memop,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data
);
    logic [31:0] shifted;
    always_comb begin
        shifted    = rdata >> {addr, 3'b000};
        be         = 4'b0000;
        wdata      = wdata_in;
        misaligned = memop;
        load_data  = rdata;
        case (funct3)
            F3_B, F3_BU: begin
                be         = 4'b0001 << addr;
                wdata      = {4{wdata_in[7:0]}};
                misaligned = 1'b0;
                load_data  = funct3[2] ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << addr;
                wdata      = {2{wdata_in[15:0]}};
                misaligned = memop & addr[0];
                load_data  = funct3[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            end
            F3_W: begin
                be         = 4'b1111;
                misaligned = memop & (|addr);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage issuing loads/stores over valid/ready with stall, timeout and MEM/WB register
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALU_outM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  write_addrM,
    input  logic [31:0] PC_plus4M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        stallM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [31:0] ALU_outW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  write_addrW,
    output logic [31:0] PC_plus4W,
    output logic        mem_errW
);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic memop, misaligned, timeout, err;
    logic [3:0] be;
    logic [31:0] wdata, load_data;

    load_store_align u_align (
        .funct3    (funct3M),
        .addr      (ALU_outM[1:0]),
        .memop     (memop),
        .wdata_in  (WriteDataM),
        .rdata     (dmem_rdata),
        .be        (be),
        .wdata     (wdata),
        .misaligned(misaligned),
        .load_data (load_data)
    );

    assign memop   = MemWriteM | (ResultSrcM == RS_LOAD);
    assign timeout = (state == S_WAIT) && (cnt == CNT_W'(TIMEOUT));
    assign err     = misaligned | timeout;
    // gating with reset keeps the bus quiet while reset is held, even mid-access
    assign dmem_req   = reset & memop & ~misaligned & ~timeout;
    assign dmem_we    = dmem_req & MemWriteM;
    assign dmem_addr  = dmem_req ? {ALU_outM[31:2], 2'b00} : 32'b0;
    assign dmem_be    = dmem_req ? be : 4'b0;
    assign dmem_wdata = dmem_req ? wdata : 32'b0;
    assign stallM     = dmem_req & ~dmem_ready;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == S_IDLE) begin
            if (stallM) begin
                state_n = S_WAIT;
                cnt_n   = CNT_W'(1);
            end
        end else if (dmem_ready | timeout) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= '0;
            ALU_outW    <= '0;
            ReadDataW   <= '0;
            write_addrW <= '0;
            PC_plus4W   <= '0;
            mem_errW    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            RegWriteW   <= RegWriteM & ~stallM & ~err;
            ResultSrcW  <= stallM ? 2'b0 : ResultSrcM;
            ALU_outW    <= stallM ? 32'b0 : ALU_outM;
            ReadDataW   <= (dmem_req & dmem_ready & ~MemWriteM) ? load_data : 32'b0;
            write_addrW <= stallM ? 5'b0 : write_addrM;
            PC_plus4W   <= stallM ? 32'b0 : PC_plus4M;
            mem_errW    <= err;
        end
    end
endmodule
